// File: rtl/sim_mem_arb_pkg.sv
// Shared types for the simulation-memory port arbiter: FSM states and the
// completion tag that travels alongside each memory access.
package sim_mem_arb_pkg;

  localparam int TAG_ID_W = 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                wr;
  } tag_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index at or after ptr,
// wrapping modulo NREQ.
module rr_picker
  import sim_mem_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any_valid
);

  always_comb begin : pick
    int j;
    j         = 0;
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any_valid && valid[j]) begin
        any_valid = 1'b1;
        grant[j]  = 1'b1;
        idx       = IW'(j);
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/sim_mem_port_arbiter.sv
// Shares one port of the dual-port simulation memory between NREQ requesters,
// with an optional zero-fill after reset and tag-routed completions.
module sim_mem_port_arbiter
  import sim_mem_arb_pkg::*;
#(
  parameter  int NREQ           = 4,
  parameter  int WIDTH          = 16,
  parameter  int LENGTH         = 32,
  parameter  int DELAY          = 1,
  parameter  bit CLEAR_ON_RESET = 1'b1,
  localparam int AW             = $clog2(LENGTH),
  localparam int IW             = idx_width(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       reqValid_i,
  output logic [NREQ-1:0]       reqReady_o,
  input  logic [NREQ-1:0]       reqWr_i,
  input  logic [NREQ*AW-1:0]    reqAddr_i,
  input  logic [NREQ*WIDTH-1:0] reqData_i,
  output logic [NREQ-1:0]       rspValid_o,
  output logic [WIDTH-1:0]      rspData_o,
  output logic                  memEn_o,
  output logic                  memWr_o,
  output logic [AW-1:0]         memAddr_o,
  output logic [WIDTH-1:0]      memDataIn_o,
  input  logic [WIDTH-1:0]      memDataOut_i,
  output logic                  initDone_o
);

  arb_state_e      state_r, state_next_s;
  logic [AW-1:0]   clr_cnt_r;
  logic [IW-1:0]   ptr_r;
  tag_t            tag_r [DELAY];
  logic [NREQ-1:0] grant_s;
  logic [IW-1:0]   gidx_s;
  logic            any_s;
  logic            fire_s;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .valid     (reqValid_i),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .idx       (gidx_s),
    .any_valid (any_s)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == AW'(LENGTH - 1)) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_CLEAR;
    endcase
  end

  // Outputs are forced low while reset is held, whatever the state register says.
  always_comb begin
    reqReady_o  = '0;
    memEn_o     = 1'b0;
    memWr_o     = 1'b0;
    memAddr_o   = '0;
    memDataIn_o = '0;
    fire_s      = 1'b0;
    if (!rst_ni) begin
      fire_s = 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          memEn_o   = 1'b1;
          memWr_o   = 1'b1;
          memAddr_o = clr_cnt_r;
        end
        ST_RUN: begin
          fire_s     = any_s;
          reqReady_o = grant_s;
          if (any_s) begin
            memEn_o     = 1'b1;
            memWr_o     = reqWr_i[gidx_s];
            memAddr_o   = reqAddr_i[int'(gidx_s)*AW +: AW];
            memDataIn_o = reqData_i[int'(gidx_s)*WIDTH +: WIDTH];
          end else begin
            memEn_o = 1'b0;
          end
        end
        default: fire_s = 1'b0;
      endcase
    end
  end

  // Clear address counter; parks on LENGTH-1 so odd lengths never wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clr_cnt_r <= '0;
    end else if (state_r == ST_CLEAR && clr_cnt_r != AW'(LENGTH - 1)) begin
      clr_cnt_r <= clr_cnt_r + AW'(1);
    end else begin
      clr_cnt_r <= clr_cnt_r;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_r <= '0;
    end else if (fire_s) begin
      ptr_r <= (int'(gidx_s) == NREQ - 1) ? '0 : gidx_s + IW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Tag pipe mirrors the memory output buffer stage for stage, idle slots included.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DELAY; i++) tag_r[i] <= '0;
    end else begin
      tag_r[DELAY-1] <= {fire_s, TAG_ID_W'(gidx_s), memWr_o & fire_s};
      for (int i = 0; i < DELAY - 1; i++) tag_r[i] <= tag_r[i+1];
    end
  end

  always_comb begin
    rspValid_o = '0;
    rspData_o  = '0;
    if (tag_r[0].valid) begin
      rspValid_o[tag_r[0].id[IW-1:0]] = 1'b1;
      rspData_o = tag_r[0].wr ? '0 : memDataOut_i;
    end else begin
      rspData_o = '0;
    end
  end

  assign initDone_o = rst_ni && (state_r == ST_RUN);

endmodule

// File: tb/tb_sim_mem_port_arbiter.sv
// Randomized bench for sim_mem_port_arbiter with a behavioural memory and a
// transaction-level reference model of arbitration and completions.
module tb_sim_mem_port_arbiter;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 16;
  localparam int LENGTH = 32;
  localparam int DELAY  = 3;
  localparam int AW     = $clog2(LENGTH);
  localparam int VW     = 2*NREQ + 2*WIDTH + AW + 3;

  logic                  clk = 1'b0;
  logic                  rst_ni = 1'b1;
  logic [NREQ-1:0]       reqValid_i = '0;
  logic [NREQ-1:0]       reqReady_o;
  logic [NREQ-1:0]       reqWr_i = '0;
  logic [NREQ*AW-1:0]    reqAddr_i = '0;
  logic [NREQ*WIDTH-1:0] reqData_i = '0;
  logic [NREQ-1:0]       rspValid_o;
  logic [WIDTH-1:0]      rspData_o;
  logic                  memEn_o, memWr_o, initDone_o;
  logic [AW-1:0]         memAddr_o;
  logic [WIDTH-1:0]      memDataIn_o, memDataOut_i;

  sim_mem_port_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .LENGTH(LENGTH), .DELAY(DELAY), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .reqValid_i(reqValid_i), .reqReady_o(reqReady_o), .reqWr_i(reqWr_i),
    .reqAddr_i(reqAddr_i), .reqData_i(reqData_i),
    .rspValid_o(rspValid_o), .rspData_o(rspData_o),
    .memEn_o(memEn_o), .memWr_o(memWr_o), .memAddr_o(memAddr_o),
    .memDataIn_o(memDataIn_o), .memDataOut_i(memDataOut_i), .initDone_o(initDone_o)
  );

  always #5 clk = ~clk;

  // Simulation memory: random power-up contents, DELAY-stage output buffer,
  // garbage on the buffer whenever the cycle is not a read.
  logic [WIDTH-1:0] mem [LENGTH];
  logic [WIDTH-1:0] mpipe [DELAY];
  logic seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < LENGTH; i++) mem[i] <= WIDTH'($urandom);
      seeded <= 1'b1;
    end else if (memEn_o && memWr_o) begin
      mem[memAddr_o] <= memDataIn_o;
    end
    mpipe[DELAY-1] <= (memEn_o && !memWr_o) ? mem[memAddr_o] : WIDTH'($urandom);
    for (int i = 0; i < DELAY - 1; i++) mpipe[i] <= mpipe[i+1];
  end
  assign memDataOut_i = mpipe[0];

  // Reference model state
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               m_ptr = 0;
  int               m_clr = 0;
  logic [WIDTH-1:0] ref_mem [LENGTH];
  logic             r_v [64];
  int               r_id [64];
  logic [WIDTH-1:0] r_d [64];
  logic             p_v [NREQ];
  logic             p_w [NREQ];
  logic [AW-1:0]    p_a [NREQ];
  logic [WIDTH-1:0] p_d [NREQ];
  logic [VW-1:0]    got, exp;

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      reqValid_i[i]               = p_v[i];
      reqWr_i[i]                  = p_w[i];
      reqAddr_i[i*AW +: AW]       = p_a[i];
      reqData_i[i*WIDTH +: WIDTH] = p_d[i];
    end
  endtask

  task automatic sample_outputs(output logic [VW-1:0] o);
    o = {reqReady_o, rspValid_o, rspData_o, memEn_o, memWr_o, memAddr_o, memDataIn_o, initDone_o};
  endtask

  task automatic model_reset();
    for (int s = 0; s < 64; s++) r_v[s] = 1'b0;
    m_ptr = 0;
    m_clr = LENGTH;
  endtask

  task automatic clear_pending();
    for (int i = 0; i < NREQ; i++) p_v[i] = 1'b0;
  endtask

  task automatic new_req(input int i, input logic wr, input int addr, input logic [WIDTH-1:0] d);
    p_v[i] = 1'b1;
    p_w[i] = wr;
    p_a[i] = AW'(addr);
    p_d[i] = d;
  endtask

  // One clock of stimulus plus the reference model's view of that clock.
  task automatic run_cycle(output logic [VW-1:0] o, output logic [VW-1:0] e);
    int g, slot, s2;
    logic [NREQ-1:0] e_rdy, e_rv;
    logic [WIDTH-1:0] e_rd, e_din;
    logic e_en, e_wr;
    logic [AW-1:0] e_a;
    drive_inputs();
    @(negedge clk);
    g = -1; e_rdy = '0; e_en = 1'b0; e_wr = 1'b0; e_a = '0; e_din = '0;
    if (m_clr > 0) begin
      e_en = 1'b1; e_wr = 1'b1; e_a = AW'(LENGTH - m_clr);
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (g < 0 && p_v[j]) g = j;
      end
      if (g >= 0) begin
        e_rdy[g] = 1'b1; e_en = 1'b1; e_wr = p_w[g]; e_a = p_a[g]; e_din = p_d[g];
      end
    end
    slot = cyc % 64;
    e_rv = '0; e_rd = '0;
    if (r_v[slot]) begin
      e_rv[r_id[slot]] = 1'b1;
      e_rd = r_d[slot];
    end
    e = {e_rdy, e_rv, e_rd, e_en, e_wr, e_a, e_din, (m_clr == 0)};
    sample_outputs(o);
    @(posedge clk);
    r_v[slot] = 1'b0;
    if (m_clr > 0) begin
      ref_mem[e_a] = '0;
      m_clr--;
    end else if (g >= 0) begin
      s2 = (cyc + DELAY) % 64;
      r_v[s2]  = 1'b1;
      r_id[s2] = g;
      r_d[s2]  = p_w[g] ? '0 : ref_mem[p_a[g]];
      if (p_w[g]) ref_mem[p_a[g]] = p_d[g];
      m_ptr  = (g + 1) % NREQ;
      p_v[g] = 1'b0;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) new_req(i, 1'($urandom), $urandom_range(LENGTH-1), WIDTH'($urandom));
    drive_inputs();
    #2 rst_ni = 1'b0;
    model_reset();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      sample_outputs(got);
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL reset n=%0d got=%h exp=0", n, got);
      end
    end
    @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  // Requests stay held throughout the clear; they must only be served afterwards.
  task automatic test_clear();
    for (int c = 0; c < LENGTH + NREQ + DELAY + 2; c++) begin
      run_cycle(got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clear cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
  endtask

  task automatic test_single();
    clear_pending();
    for (int c = 0; c < DELAY + 4; c++) begin
      if (c == 0) new_req(0, 1'b1, 5, 16'hBEEF);
      if (c == 1) new_req(0, 1'b0, 5, 16'h0000);
      run_cycle(got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
  endtask

  task automatic test_round_robin();
    clear_pending();
    for (int c = 0; c < 24; c++) begin
      if (c < 8) new_req(0, 1'b1, c, WIDTH'($urandom));
      else if (c < 20) begin
        for (int i = 0; i < NREQ; i++)
          if (!p_v[i]) new_req(i, 1'b0, $urandom_range(7), '0);
      end else clear_pending();
      run_cycle(got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL round_robin cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
  endtask

  task automatic test_gaps();
    clear_pending();
    for (int c = 0; c < DELAY + 6; c++) begin
      if (c == 0) new_req(2, 1'b0, 1, '0);
      if (c == 2) new_req(0, 1'b0, 2, '0);
      if (c == 3) new_req(1, 1'b0, 3, '0);
      run_cycle(got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL gaps cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
  endtask

  task automatic test_starvation();
    clear_pending();
    for (int c = 0; c < DELAY + 7; c++) begin
      if (c == 0) new_req(3, 1'b0, 4, '0);
      if (c == 1) begin new_req(0, 1'b0, 5, '0); new_req(1, 1'b0, 6, '0); end
      if (c == 2) new_req(0, 1'b0, 7, '0);
      if (c == 3) begin new_req(0, 1'b0, 1, '0); new_req(3, 1'b0, 2, '0); end
      run_cycle(got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL starvation cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
  endtask

  task automatic test_random();
    clear_pending();
    for (int c = 0; c < 400; c++) begin
      if (c < 400 - (DELAY + NREQ + 2)) begin
        for (int i = 0; i < NREQ; i++)
          if (!p_v[i] && $urandom_range(1) == 1)
            new_req(i, 1'($urandom), $urandom_range(LENGTH-1), WIDTH'($urandom));
      end
      run_cycle(got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_pending();
    new_req(0, 1'b0, 3, '0);
    new_req(1, 1'b0, 4, '0);
    for (int c = 0; c < 2; c++) begin
      run_cycle(got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
    new_req(2, 1'b0, 5, '0);
    drive_inputs();
    rst_ni = 1'b0;
    model_reset();
    for (int n = 0; n < 3; n++) begin
      if (n == 0) #2; else @(negedge clk);
      sample_outputs(got);
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL reset_mid_hold n=%0d got=%h exp=0", n, got);
      end
    end
    @(posedge clk);
    clear_pending();
    #1 rst_ni = 1'b1;
    for (int c = 0; c < LENGTH + DELAY + 3; c++) begin
      run_cycle(got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 64; s++) r_v[s] = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      p_v[i] = 1'b0; p_w[i] = 1'b0; p_a[i] = '0; p_d[i] = '0;
    end
    test_reset();
    test_clear();
    test_single();
    test_round_robin();
    test_gaps();
    test_starvation();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
